spi_flash_reader: RTL and testbench
===================================

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCK half-period in clock cycles, legal range 1..255.
REQ-002 SHALL have port clock, input, 1: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port resetb, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1: one-cycle request; sampled only while busy=0.
REQ-005 SHALL have port addr, input, 24: flash byte address; captured when start is accepted.
REQ-006 SHALL have port len, input, 16: byte count; captured when start is accepted.
REQ-007 SHALL have port busy, output, 1: transfer in progress.
REQ-008 SHALL have port data, output, 8: received byte.
REQ-009 SHALL have port data_valid, output, 1: data holds an unconsumed byte.
REQ-010 SHALL have port data_ready, input, 1: consumer accepts the byte when data_valid=1 and data_ready=1.
REQ-011 SHALL have port done, output, 1: one-cycle pulse marking the end of a transfer.
REQ-012 SHALL have ports flash_csb, output, 1; flash_clk, output, 1; flash_io0, output, 1 (MOSI); flash_io1, input, 1 (MISO).

Function
REQ-013 SHALL use SPI mode 0:
- flash_clk idles low.
- flash_io0 changes only while flash_clk is low.
- flash_io1 is sampled on the cycle in which flash_clk rises.
- All bits are sent and received MSB first.
REQ-014 SHALL implement states IDLE, WAKE, WGAP, CMD, ADDR, DATA, STALL, END:
- IDLE -> CMD on an accepted start with len!=0 (IDLE -> WAKE instead, per REQ-026).
- CMD -> ADDR after 8 bits.
- ADDR -> DATA after 24 bits.
- DATA -> STALL or DATA at each byte boundary.
- DATA -> END after the last bit.
- END -> IDLE.
REQ-015 SHALL, one cycle after start is accepted, drive flash_csb low and busy high. The first flash_clk rise SHALL occur CLK_DIV cycles after flash_csb falls.
REQ-016 SHALL send command byte 0x03, then addr[23:0]. flash_io0 SHALL be held 0 during DATA.
REQ-017 SHALL provide a one-byte holding register:
- After the 8th sampled bit of a byte, load data and set data_valid on the next cycle.
- data_valid SHALL clear on the cycle after a handshake.
REQ-018 SHALL, at a byte boundary where the holding register is still full and more bytes remain, enter STALL:
- flash_clk is held low.
- DATA resumes on the cycle after the handshake, with no bit lost or duplicated.
REQ-019 SHALL, after the last bit of byte len-1, drive flash_clk low and flash_csb high. flash_csb SHALL then remain high for at least 2*CLK_DIV cycles before busy falls.
REQ-020 SHALL pulse done on the cycle busy falls. That cycle SHALL be no earlier than the handshake of the last byte.
REQ-021 SHALL ignore start while busy=1; addr and len are not re-captured.
REQ-022 SHALL treat len=0 as a no-op:
- flash_csb stays high and busy stays low.
- done pulses on the cycle after start.
REQ-023 SHALL allow data_ready to be held high continuously. In that case no STALL occurs and the SCK period is exactly 2*CLK_DIV cycles throughout.

Reset
REQ-024 SHALL, while resetb=0, force asynchronously: flash_csb=1, flash_clk=0, flash_io0=0, busy=0, data_valid=0, done=0, data=0x00, state=IDLE.
REQ-025 SHALL, on reset assertion mid-transfer, abort immediately. Any pending byte is discarded, no done pulse is issued, and the first start after release begins a fresh transfer.

Configuration
REQ-026 SHALL support macro SPI_FLASH_WAKEUP_EN.
- When defined: the first accepted start with len!=0 after reset SHALL first send a standalone 0xAB frame (WAKE), then hold flash_csb high for 8*CLK_DIV cycles (WGAP), then continue with CMD. Later transfers skip WAKE and WGAP.
- When undefined: states WAKE and WGAP and their flag SHALL not be synthesized, and every transfer starts at CMD.

Verification
REQ-027 SHALL cover: CLK_DIV=2, addr=0x000010, len=4, data_ready=1, flash model returns 0xDE 0xAD 0xBE 0xEF -> io0 carries 0x03 0x00 0x00 0x10; data shows DE, AD, BE, EF; 64 SCK rises; one done pulse.
REQ-028 SHALL cover: len=3, data_ready=0 for 40 cycles after the first data_valid -> flash_clk stays low from the byte-1 boundary until the handshake; all three bytes are received intact.
REQ-029 SHALL cover: len=0 -> flash_csb never falls; done on the cycle after start.
REQ-030 SHALL cover: start asserted again during a len=2 transfer with addr=0x123456 -> ignored; the captured addr is unchanged and exactly 2 bytes are delivered.
REQ-031 SHALL cover: resetb pulsed low during ADDR -> flash_csb=1 and busy=0 within the same cycle; a following len=1 read completes normally.
REQ-032 SHALL cover, with SPI_FLASH_WAKEUP_EN: two back-to-back reads -> 0xAB appears only before the first 0x03, with csb high for at least 16 cycles (CLK_DIV=2) between the two frames.

Source files
------------

// File: rtl/spi_flash_reader.sv
// SPI flash reader: issues 0x03 READ frames in SPI mode 0 and streams bytes out through a one-byte holding register.
// Defining SPI_FLASH_WAKEUP_EN adds a one-time 0xAB release-from-power-down frame after reset.
module spi_flash_reader #(
    parameter int CLK_DIV = 2
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic [7:0]  data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        done,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DATA, STALL, END
`ifdef SPI_FLASH_WAKEUP_EN
        , WAKE, WGAP
`endif
    } state_t;

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [10:0] END_LAST = 11'(2 * CLK_DIV - 1);
`ifdef SPI_FLASH_WAKEUP_EN
    localparam logic [10:0] GAP_LAST = 11'(8 * CLK_DIV - 1);
`endif

    state_t      state_q, state_d;
    logic [7:0]  divCnt_q, divCnt_d;
    logic [10:0] gapCnt_q, gapCnt_d;
    logic [4:0]  bitCnt_q, bitCnt_d;
    logic [15:0] byteCnt_q, byteCnt_d;
    logic [31:0] txShift_q, txShift_d;
    logic [6:0]  rxShift_q, rxShift_d;
    logic        csb_q, csb_d;
    logic        sck_q, sck_d;
    logic [7:0]  data_q, data_d;
    logic        dataValid_q, dataValid_d;
    logic        done_q, done_d;
`ifdef SPI_FLASH_WAKEUP_EN
    logic [23:0] addr_q, addr_d;
    logic        wokeUp_q, wokeUp_d;
`endif

    logic shifting, tick, rise, fall;

    always_comb begin
        shifting = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
`ifdef SPI_FLASH_WAKEUP_EN
        if (state_q == WAKE) shifting = 1'b1;
`endif
    end

    assign tick = (divCnt_q == DIV_LAST);
    assign rise = shifting && tick && !sck_q;
    assign fall = shifting && tick && sck_q;

    always_comb begin
        state_d     = state_q;
        divCnt_d    = '0;
        gapCnt_d    = gapCnt_q;
        bitCnt_d    = bitCnt_q;
        byteCnt_d   = byteCnt_q;
        txShift_d   = txShift_q;
        rxShift_d   = rxShift_q;
        csb_d       = csb_q;
        sck_d       = sck_q;
        data_d      = data_q;
        dataValid_d = dataValid_q && !data_ready;
        done_d      = 1'b0;
`ifdef SPI_FLASH_WAKEUP_EN
        addr_d      = addr_q;
        wokeUp_d    = wokeUp_q;
`endif

        if (shifting) divCnt_d = tick ? 8'd0 : divCnt_q + 8'd1;

        // MISO is captured on the edge that raises SCK; the byte lands in the holding register right away.
        if (rise) begin
            sck_d = 1'b1;
            if (state_q == DATA) begin
                rxShift_d = {rxShift_q[5:0], flash_io1};
                if (bitCnt_q == 5'd7) begin
                    data_d      = {rxShift_q, flash_io1};
                    dataValid_d = 1'b1;
                end
            end
        end

        if (fall) begin
            sck_d     = 1'b0;
            txShift_d = {txShift_q[30:0], 1'b0};
            bitCnt_d  = bitCnt_q + 5'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        csb_d     = 1'b0;
                        bitCnt_d  = '0;
                        byteCnt_d = len;
`ifdef SPI_FLASH_WAKEUP_EN
                        addr_d    = addr;
                        if (!wokeUp_q) begin
                            wokeUp_d  = 1'b1;
                            state_d   = WAKE;
                            txShift_d = {8'hAB, 24'h000000};
                        end else begin
                            state_d   = CMD;
                            txShift_d = {8'h03, addr};
                        end
`else
                        state_d   = CMD;
                        txShift_d = {8'h03, addr};
`endif
                    end
                end
            end
`ifdef SPI_FLASH_WAKEUP_EN
            WAKE: begin
                if (fall && bitCnt_q == 5'd7) begin
                    state_d  = WGAP;
                    csb_d    = 1'b1;
                    bitCnt_d = '0;
                    gapCnt_d = '0;
                end
            end
            WGAP: begin
                if (gapCnt_q == GAP_LAST) begin
                    state_d   = CMD;
                    csb_d     = 1'b0;
                    txShift_d = {8'h03, addr_q};
                end else begin
                    gapCnt_d = gapCnt_q + 11'd1;
                end
            end
`endif
            CMD: begin
                if (fall && bitCnt_q == 5'd7) begin
                    state_d  = ADDR;
                    bitCnt_d = '0;
                end
            end
            ADDR: begin
                if (fall && bitCnt_q == 5'd23) begin
                    state_d  = DATA;
                    bitCnt_d = '0;
                end
            end
            DATA: begin
                // Never start a new byte while the previous one is still unclaimed.
                if (fall && bitCnt_q == 5'd7) begin
                    bitCnt_d  = '0;
                    byteCnt_d = byteCnt_q - 16'd1;
                    if (byteCnt_q == 16'd1) begin
                        state_d  = END;
                        csb_d    = 1'b1;
                        gapCnt_d = '0;
                    end else if (dataValid_q && !data_ready) begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (!dataValid_q || data_ready) state_d = DATA;
            end
            END: begin
                if (gapCnt_q != END_LAST) begin
                    gapCnt_d = gapCnt_q + 11'd1;
                end else if (!dataValid_q || data_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= IDLE;
            divCnt_q    <= '0;
            gapCnt_q    <= '0;
            bitCnt_q    <= '0;
            byteCnt_q   <= '0;
            txShift_q   <= '0;
            rxShift_q   <= '0;
            csb_q       <= 1'b1;
            sck_q       <= 1'b0;
            data_q      <= '0;
            dataValid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef SPI_FLASH_WAKEUP_EN
            addr_q      <= '0;
            wokeUp_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            divCnt_q    <= divCnt_d;
            gapCnt_q    <= gapCnt_d;
            bitCnt_q    <= bitCnt_d;
            byteCnt_q   <= byteCnt_d;
            txShift_q   <= txShift_d;
            rxShift_q   <= rxShift_d;
            csb_q       <= csb_d;
            sck_q       <= sck_d;
            data_q      <= data_d;
            dataValid_q <= dataValid_d;
            done_q      <= done_d;
`ifdef SPI_FLASH_WAKEUP_EN
            addr_q      <= addr_d;
            wokeUp_q    <= wokeUp_d;
`endif
        end
    end

    assign busy       = (state_q != IDLE);
    assign data       = data_q;
    assign data_valid = dataValid_q;
    assign done       = done_q;
    assign flash_csb  = csb_q;
    assign flash_clk  = sck_q;
    assign flash_io0  = txShift_q[31];

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural SPI flash model; honours SPI_FLASH_WAKEUP_EN.
module tb_spi_flash_reader;

    localparam int CLK_DIV_TB = 2;

    logic        clock = 1'b0;
    logic        resetb;
    logic        start;
    logic [23:0] addr;
    logic [15:0] len;
    logic        busy;
    logic [7:0]  data;
    logic        data_valid;
    logic        data_ready;
    logic        done;
    logic        flash_csb;
    logic        flash_clk;
    logic        flash_io0;
    logic        flash_io1 = 1'b0;

    int checkCount = 0;
    int passCount  = 0;

    // Flash model and monitor state, written only by the monitor block.
    logic [7:0] rxQ[$];
    logic [7:0] mosiQ[$];
    int  doneCount = 0, csbHighBusy = 0, csbFallCnt = 0, riseCnt = 0, sckRises = 0;
    int  badPeriod = 0, lastRiseCyc = 0, cycleCount = 0;
    logic prevCsb = 1'b1, prevClk = 1'b0;
    logic [7:0] mosiShift = 8'h00;
    logic [7:0] resp [0:7];

    int rxBase, mosiBase, doneBase, riseBase, csbFallBase, periodBase, csbHighBase, wakeOfs;
    int highCnt;
    logic seen;

    spi_flash_reader #(.CLK_DIV(CLK_DIV_TB)) dut (
        .clock      (clock),
        .resetb     (resetb),
        .start      (start),
        .addr       (addr),
        .len        (len),
        .busy       (busy),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .done       (done),
        .flash_csb  (flash_csb),
        .flash_clk  (flash_clk),
        .flash_io0  (flash_io0),
        .flash_io1  (flash_io1)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        cycleCount++;
        if (done) doneCount++;
        if (data_valid && data_ready) rxQ.push_back(data);
        if (flash_csb && busy) csbHighBusy++;
        if (prevCsb && !flash_csb) begin
            csbFallCnt++;
            riseCnt = 0;
        end
        if (!flash_csb && flash_clk && !prevClk) begin
            if (riseCnt != 0 && (cycleCount - lastRiseCyc) != 2 * CLK_DIV_TB) badPeriod++;
            lastRiseCyc = cycleCount;
            riseCnt++;
            sckRises++;
            mosiShift = {mosiShift[6:0], flash_io0};
            if (riseCnt % 8 == 0) mosiQ.push_back(mosiShift);
        end
        if (!flash_csb && !flash_clk && prevClk && riseCnt >= 32) begin
            flash_io1 = resp[(riseCnt - 32) / 8][7 - ((riseCnt - 32) % 8)];
        end
        prevCsb = flash_csb;
        prevClk = flash_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [23:0] a, input logic [15:0] l);
        @(posedge clock); #1;
        start = 1'b1;
        addr  = a;
        len   = l;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int maxCycles);
        logic got;
        got = 1'b0;
        for (int i = 0; i < maxCycles && !got; i++) begin
            @(negedge clock);
            if (done) got = 1'b1;
        end
        checkOutput(tag, {31'b0, got}, 32'd1);
    endtask

    task automatic takeSnapshot();
        rxBase      = rxQ.size();
        mosiBase    = mosiQ.size();
        doneBase    = doneCount;
        riseBase    = sckRises;
        csbFallBase = csbFallCnt;
        periodBase  = badPeriod;
        csbHighBase = csbHighBusy;
    endtask

    initial begin
`ifdef SPI_FLASH_WAKEUP_EN
        wakeOfs = 1;
`else
        wakeOfs = 0;
`endif
        resetb = 1'b0; start = 1'b0; addr = '0; len = '0; data_ready = 1'b1;
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;

        repeat (3) @(negedge clock);
        checkOutput("rst_csb", flash_csb, 1);
        checkOutput("rst_clk", flash_clk, 0);
        checkOutput("rst_io0", flash_io0, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", data_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_data", data, 8'h00);
        @(posedge clock); #1 resetb = 1'b1;
        repeat (2) @(posedge clock);

        // Streaming read with the consumer always ready.
        resp[0] = 8'hDE; resp[1] = 8'hAD; resp[2] = 8'hBE; resp[3] = 8'hEF;
        takeSnapshot();
        applyStimulus(24'h000010, 16'd4);
        @(negedge clock);
        checkOutput("t1_csb_low", flash_csb, 0);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_clk_idle", flash_clk, 0);
        @(negedge clock);
        checkOutput("t1_clk_before_rise", flash_clk, 0);
        @(negedge clock);
        checkOutput("t1_first_rise", flash_clk, 1);
        waitDone("t1_done_seen", 3000);
        @(negedge clock);
        checkOutput("t1_done_pulse", done, 0);
        checkOutput("t1_busy_low", busy, 0);
        repeat (3) @(negedge clock);
        checkOutput("t1_mosi_count", mosiQ.size() - mosiBase, 8 + wakeOfs);
`ifdef SPI_FLASH_WAKEUP_EN
        checkOutput("t1_wake_byte", mosiQ[mosiBase], 8'hAB);
`endif
        checkOutput("t1_cmd", mosiQ[mosiBase + wakeOfs], 8'h03);
        checkOutput("t1_addr2", mosiQ[mosiBase + wakeOfs + 1], 8'h00);
        checkOutput("t1_addr1", mosiQ[mosiBase + wakeOfs + 2], 8'h00);
        checkOutput("t1_addr0", mosiQ[mosiBase + wakeOfs + 3], 8'h10);
        checkOutput("t1_io0_data_zero", mosiQ[mosiBase + wakeOfs + 4] | mosiQ[mosiBase + wakeOfs + 5]
                    | mosiQ[mosiBase + wakeOfs + 6] | mosiQ[mosiBase + wakeOfs + 7], 8'h00);
        checkOutput("t1_rx_count", rxQ.size() - rxBase, 4);
        checkOutput("t1_rx0", rxQ[rxBase], 8'hDE);
        checkOutput("t1_rx1", rxQ[rxBase + 1], 8'hAD);
        checkOutput("t1_rx2", rxQ[rxBase + 2], 8'hBE);
        checkOutput("t1_rx3", rxQ[rxBase + 3], 8'hEF);
        checkOutput("t1_sck_rises", sckRises - riseBase, 64 + 8 * wakeOfs);
        checkOutput("t1_sck_period", badPeriod - periodBase, 0);
        checkOutput("t1_done_count", doneCount - doneBase, 1);
        checkOutput("t1_csb_gap", (csbHighBusy - csbHighBase) >= (2 * CLK_DIV_TB + 8 * CLK_DIV_TB * wakeOfs), 1);

        // Consumer stalls after the first byte.
        resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33;
        data_ready = 1'b0;
        takeSnapshot();
        applyStimulus(24'h000100, 16'd3);
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clock);
            if (data_valid) seen = 1'b1;
        end
        checkOutput("t2_first_valid", seen, 1);
        highCnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i >= 2 && flash_clk) highCnt++;
        end
        checkOutput("t2_clk_low_stall", highCnt, 0);
        checkOutput("t2_data_held", data, 8'h11);
        checkOutput("t2_valid_held", data_valid, 1);
        @(posedge clock); #1 data_ready = 1'b1;
        waitDone("t2_done_seen", 2000);
        repeat (3) @(negedge clock);
        checkOutput("t2_cmd", mosiQ[mosiBase], 8'h03);
        checkOutput("t2_rx_count", rxQ.size() - rxBase, 3);
        checkOutput("t2_rx0", rxQ[rxBase], 8'h11);
        checkOutput("t2_rx1", rxQ[rxBase + 1], 8'h22);
        checkOutput("t2_rx2", rxQ[rxBase + 2], 8'h33);
        checkOutput("t2_sck_rises", sckRises - riseBase, 56);
        checkOutput("t2_done_count", doneCount - doneBase, 1);

        // Zero-length request.
        takeSnapshot();
        applyStimulus(24'h000055, 16'd0);
        @(negedge clock);
        checkOutput("t3_done", done, 1);
        checkOutput("t3_busy", busy, 0);
        checkOutput("t3_csb", flash_csb, 1);
        @(negedge clock);
        checkOutput("t3_done_pulse", done, 0);
        repeat (5) @(negedge clock);
        checkOutput("t3_no_csb_fall", csbFallCnt - csbFallBase, 0);
        checkOutput("t3_done_count", doneCount - doneBase, 1);

        // Second start while busy must be ignored.
        resp[0] = 8'h5A; resp[1] = 8'hA5;
        takeSnapshot();
        applyStimulus(24'h123456, 16'd2);
        repeat (10) @(posedge clock);
        #1 start = 1'b1; addr = 24'hFFFFFF; len = 16'd5;
        @(posedge clock); #1 start = 1'b0;
        waitDone("t4_done_seen", 2000);
        repeat (20) @(negedge clock);
        checkOutput("t4_cmd", mosiQ[mosiBase], 8'h03);
        checkOutput("t4_addr2", mosiQ[mosiBase + 1], 8'h12);
        checkOutput("t4_addr1", mosiQ[mosiBase + 2], 8'h34);
        checkOutput("t4_addr0", mosiQ[mosiBase + 3], 8'h56);
        checkOutput("t4_rx_count", rxQ.size() - rxBase, 2);
        checkOutput("t4_rx0", rxQ[rxBase], 8'h5A);
        checkOutput("t4_rx1", rxQ[rxBase + 1], 8'hA5);
        checkOutput("t4_one_frame", csbFallCnt - csbFallBase, 1);
        checkOutput("t4_done_count", doneCount - doneBase, 1);
        checkOutput("t4_idle", busy, 0);

        // Reset during the address phase, then a fresh single-byte read.
        takeSnapshot();
        applyStimulus(24'h000040, 16'd4);
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clock);
            if (!flash_csb && riseCnt >= 12) seen = 1'b1;
        end
        checkOutput("t5_reached_addr", seen, 1);
        @(posedge clock); #2 resetb = 1'b0;
        #1;
        checkOutput("t5_abort_csb", flash_csb, 1);
        checkOutput("t5_abort_busy", busy, 0);
        checkOutput("t5_abort_clk", flash_clk, 0);
        repeat (3) @(posedge clock);
        #1 resetb = 1'b1;
        repeat (10) @(negedge clock);
        checkOutput("t5_no_done_abort", doneCount - doneBase, 0);
        checkOutput("t5_no_byte_abort", rxQ.size() - rxBase, 0);
        resp[0] = 8'h77;
        takeSnapshot();
        applyStimulus(24'h000200, 16'd1);
        waitDone("t5_done_seen", 2000);
        repeat (3) @(negedge clock);
        checkOutput("t5_rx_count", rxQ.size() - rxBase, 1);
        checkOutput("t5_rx0", rxQ[rxBase], 8'h77);
        checkOutput("t5_done_count", doneCount - doneBase, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
